// File: rtl/mem_wb_stage_reg_if.sv
// MEM->WB stage bus: MEM-side request, WB-side entry and the EX bypass tap.
interface mem_wb_stage_reg_if #(
  parameter int DATA_WIDTH   = 64,
  parameter int NUM_REGS_LOG = 5
);
  logic                    flush;
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_reg_write;
  logic                    in_mem_to_reg;
  logic [NUM_REGS_LOG-1:0] in_dest;
  logic [DATA_WIDTH-1:0]   in_alu;
  logic [DATA_WIDTH-1:0]   in_mem_data;
  logic [1:0]              in_size;
  logic                    in_unsigned;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_reg_write;
  logic                    out_mem_to_reg;
  logic [NUM_REGS_LOG-1:0] out_dest;
  logic [DATA_WIDTH-1:0]   out_alu;
  logic [DATA_WIDTH-1:0]   out_mem_data;
  logic [DATA_WIDTH-1:0]   out_wb_data;
  logic                    out_misaligned;
  logic                    fwd_valid;
  logic [NUM_REGS_LOG-1:0] fwd_dest;
  logic [DATA_WIDTH-1:0]   fwd_data;

  modport master (
    output flush, in_valid, in_reg_write, in_mem_to_reg, in_dest, in_alu,
           in_mem_data, in_size, in_unsigned, out_ready,
    input  in_ready, out_valid, out_reg_write, out_mem_to_reg, out_dest,
           out_alu, out_mem_data, out_wb_data, out_misaligned,
           fwd_valid, fwd_dest, fwd_data
  );

  modport slave (
    input  flush, in_valid, in_reg_write, in_mem_to_reg, in_dest, in_alu,
           in_mem_data, in_size, in_unsigned, out_ready,
    output in_ready, out_valid, out_reg_write, out_mem_to_reg, out_dest,
           out_alu, out_mem_data, out_wb_data, out_misaligned,
           fwd_valid, fwd_dest, fwd_data
  );
endinterface

// File: rtl/mem_wb_stage_reg.sv
// Elastic MEM/WB register: main + skid entry, load alignment/extension at the
// input, registered writeback mux and EX bypass tap.
module mem_wb_stage_reg #(
  parameter  int DATA_WIDTH   = 64,
  parameter  int NUM_REGS_LOG = 5,
  localparam int OFFS_W       = $clog2(DATA_WIDTH/8)
) (
  input logic clk,
  input logic reset,
  mem_wb_stage_reg_if.slave bus
);

  typedef struct packed {
    logic                    reg_write;
    logic                    mem_to_reg;
    logic [NUM_REGS_LOG-1:0] dest;
    logic [DATA_WIDTH-1:0]   alu;
    logic [DATA_WIDTH-1:0]   mem_data;
    logic [DATA_WIDTH-1:0]   wb_data;
    logic                    misaligned;
  } entry_t;

  entry_t              nxt, main_e, skid_e;
  logic                main_valid, skid_valid;
  logic [OFFS_W-1:0]   off, amask;
  logic [DATA_WIDTH-1:0] shifted, lowmask, ext;
  logic                sbit, mis;
  logic                accept, release_e;

  // Extraction happens before the flops so the WB mux output is registered.
  always_comb begin
    off     = bus.in_alu[OFFS_W-1:0];
    shifted = bus.in_mem_data >> {off, 3'b000};
    lowmask = '1;
    sbit    = shifted[DATA_WIDTH-1];
    amask   = OFFS_W'(7);
    case (bus.in_size)
      2'd0: begin lowmask = DATA_WIDTH'(8'hFF);         sbit = shifted[7];  amask = '0;         end
      2'd1: begin lowmask = DATA_WIDTH'(16'hFFFF);      sbit = shifted[15]; amask = OFFS_W'(1); end
      2'd2: begin lowmask = DATA_WIDTH'(32'hFFFF_FFFF); sbit = shifted[31]; amask = OFFS_W'(3); end
      default: ;
    endcase
    mis = ((off & amask) != '0) || (bus.in_size == 2'd3 && DATA_WIDTH == 32);
    ext = (shifted & lowmask) | ((sbit && !bus.in_unsigned) ? ~lowmask : '0);

    nxt            = '0;
    nxt.reg_write  = bus.in_reg_write;
    nxt.mem_to_reg = bus.in_mem_to_reg;
    nxt.dest       = bus.in_dest;
    nxt.alu        = bus.in_alu;
    if (bus.in_mem_to_reg) begin
      nxt.misaligned = mis;
      nxt.mem_data   = mis ? '0 : ext;
    end
    nxt.wb_data = bus.in_mem_to_reg ? nxt.mem_data : bus.in_alu;
  end

  // in_ready depends only on the skid flop, never on out_ready.
  assign accept    = bus.in_valid & ~skid_valid;
  assign release_e = main_valid & bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_e     <= '0;
      skid_e     <= '0;
    end else if (bus.flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || release_e) begin
      if (skid_valid) begin
        main_e     <= skid_e;
        main_valid <= 1'b1;
        skid_valid <= accept;
        if (accept) skid_e <= nxt;
      end else begin
        main_valid <= accept;
        if (accept) main_e <= nxt;
      end
    end else if (accept) begin
      skid_e     <= nxt;
      skid_valid <= 1'b1;
    end
  end

  assign bus.in_ready       = ~skid_valid;
  assign bus.out_valid      = main_valid;
  assign bus.out_reg_write  = main_e.reg_write;
  assign bus.out_mem_to_reg = main_e.mem_to_reg;
  assign bus.out_dest       = main_e.dest;
  assign bus.out_alu        = main_e.alu;
  assign bus.out_mem_data   = main_e.mem_data;
  assign bus.out_wb_data    = main_e.wb_data;
  assign bus.out_misaligned = main_e.misaligned;
  assign bus.fwd_valid      = main_valid & main_e.reg_write & (main_e.dest != '0);
  assign bus.fwd_dest       = main_e.dest;
  assign bus.fwd_data       = main_e.wb_data;

endmodule
